// File: rtl/r2rv_pkg.sv
// rtl/r2rv_pkg.sv - shared buffer sizing, tag type and entry types for the reorder buffer slice
package r2rv_pkg;

  localparam int BUF_SIZE_LOG = 4;
  localparam int BUF_SIZE     = 2 ** BUF_SIZE_LOG;

  // Tags carry one extra wrap bit so full and empty stay distinguishable.
  typedef logic [BUF_SIZE_LOG:0]   tag_t;
  typedef logic [BUF_SIZE_LOG-1:0] idx_t;

  typedef enum logic [1:0] {
    S_NOT_USED,
    S_DISPATCHED,
    S_EXECUTED
  } entry_state_e;

  typedef struct packed {
    entry_state_e state;
    logic         is_store;
    tag_t         tag;
  } entry_t;

  function automatic idx_t tag_idx(input tag_t t);
    return t[BUF_SIZE_LOG-1:0];
  endfunction

endpackage

// File: rtl/rob_squash_mask.sv
// rtl/rob_squash_mask.sv - wrap-aware entry mask covering tags from_tag up to (not including) to_tag
module rob_squash_mask
  import r2rv_pkg::*;
(
  input  tag_t                from_tag,
  input  tag_t                to_tag,
  output logic [BUF_SIZE-1:0] mask
);

  tag_t span;
  idx_t off;

  // An entry is inside the range when its distance from from_tag is below the span.
  always_comb begin
    span = to_tag - from_tag;
    mask = '0;
    off  = '0;
    for (int i = 0; i < BUF_SIZE; i++) begin
      off     = idx_t'(i) - tag_idx(from_tag);
      mask[i] = ({1'b0, off} < span);
    end
  end

endmodule

// File: rtl/rob_controller.sv
// rtl/rob_controller.sv - head/tail pointers, in-order dual retire and flush truncation for the reorder buffer
module rob_controller
  import r2rv_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    dispatch_valid,
  output logic                    dispatch_ready,
  output tag_t                    dispatch_tag,
  input  logic [1:0]              head_executed,
  input  logic [1:0]              head_is_store,
  output logic [1:0]              commit_valid,
  output idx_t                    commit_idx0,
  output idx_t                    commit_idx1,
  input  logic                    flush,
  input  tag_t                    flush_tag,
  output logic                    flush_err,
  output logic [BUF_SIZE-1:0]     squash_mask,
  output tag_t                    count,
  output logic                    full,
  output logic                    empty
);

  tag_t                head_q, head_d;
  tag_t                tail_q, tail_d;
  logic [BUF_SIZE-1:0] squash_q, squash_d;
  logic                err_q, err_d;

  tag_t                count_w;
  tag_t                flush_off;
  tag_t                squash_from;
  logic [BUF_SIZE-1:0] squash_w;
  logic                alloc;
  logic                flush_ok;
  logic [1:0]          n_commit;

  assign count_w = tail_q - head_q;
  assign count   = count_w;
  assign empty   = (head_q == tail_q);
  assign full    = (tag_idx(head_q) == tag_idx(tail_q)) &&
                   (head_q[BUF_SIZE_LOG] != tail_q[BUF_SIZE_LOG]);

  assign dispatch_ready = !full && !flush;
  assign alloc          = dispatch_valid && dispatch_ready;
  assign dispatch_tag   = tail_q;

  assign flush_off   = flush_tag - head_q;
  assign flush_ok    = flush && (flush_off < count_w);
  assign squash_from = flush_tag + tag_t'(1);

  // Slot 1 must not retire past the kept branch when the branch itself sits at the head.
  assign commit_valid[0] = !empty && head_executed[0];
  assign commit_valid[1] = commit_valid[0] && (count_w >= tag_t'(2)) && head_executed[1] &&
                           !head_is_store[0] && !head_is_store[1] &&
                           !(flush_ok && (flush_off == '0));
  assign commit_idx0     = tag_idx(head_q);
  assign commit_idx1     = tag_idx(head_q) + idx_t'(1);
  assign n_commit        = {1'b0, commit_valid[0]} + {1'b0, commit_valid[1]};

  rob_squash_mask u_squash_mask (
    .from_tag (squash_from),
    .to_tag   (tail_q),
    .mask     (squash_w)
  );

  always_comb begin
    head_d   = head_q + tag_t'(n_commit);
    tail_d   = tail_q;
    squash_d = '0;
    err_d    = flush && !flush_ok;
    if (flush_ok) begin
      tail_d   = squash_from;
      squash_d = squash_w;
    end else if (alloc) begin
      tail_d = tail_q + tag_t'(1);
    end
  end

  // The buffer array updates on the falling edge, so the pointers follow it.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      squash_q <= '0;
      err_q    <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      squash_q <= squash_d;
      err_q    <= err_d;
    end
  end

  assign squash_mask = squash_q;
  assign flush_err   = err_q;

endmodule

// File: tb/tb_rob_controller.sv
// tb/tb_rob_controller.sv - directed and randomized checks of rob_controller against a queue-based model
module tb_rob_controller;
  import r2rv_pkg::*;

  logic                clk = 1'b1;
  logic                reset;
  logic                dispatch_valid;
  logic                dispatch_ready;
  tag_t                dispatch_tag;
  logic [1:0]          head_executed;
  logic [1:0]          head_is_store;
  logic [1:0]          commit_valid;
  idx_t                commit_idx0;
  idx_t                commit_idx1;
  logic                flush;
  tag_t                flush_tag;
  logic                flush_err;
  logic [BUF_SIZE-1:0] squash_mask;
  tag_t                count;
  logic                full;
  logic                empty;

  int vectors     = 0;
  int miscompares = 0;

  // Model: queue of occupied tags, oldest first.
  int             q[$];
  int             nxt;
  logic [15:0]    m_sq;
  logic           m_err;

  always #5 clk = ~clk;

  rob_controller dut (
    .clk            (clk),
    .reset          (reset),
    .dispatch_valid (dispatch_valid),
    .dispatch_ready (dispatch_ready),
    .dispatch_tag   (dispatch_tag),
    .head_executed  (head_executed),
    .head_is_store  (head_is_store),
    .commit_valid   (commit_valid),
    .commit_idx0    (commit_idx0),
    .commit_idx1    (commit_idx1),
    .flush          (flush),
    .flush_tag      (flush_tag),
    .flush_err      (flush_err),
    .squash_mask    (squash_mask),
    .count          (count),
    .full           (full),
    .empty          (empty)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic dv, input logic [1:0] he, input logic [1:0] st,
                       input logic fl, input logic [4:0] ft);
    dispatch_valid = dv;
    head_executed  = he;
    head_is_store  = st;
    flush          = fl;
    flush_tag      = ft;
  endtask

  task automatic model_clear();
    q.delete();
    nxt   = 0;
    m_sq  = '0;
    m_err = 1'b0;
  endtask

  task automatic check_state();
    check("count", 32'(count), 32'(q.size()));
    check("empty", 32'(empty), 32'(q.size() == 0));
    check("full", 32'(full), 32'(q.size() == 16));
    check("dispatch_tag", 32'(dispatch_tag), 32'(nxt));
    check("squash_mask", 32'(squash_mask), 32'(m_sq));
    check("flush_err", 32'(flush_err), 32'(m_err));
  endtask

  // One clock: entered and left at posedge+1, DUT state moves on the negedge in between.
  task automatic cycle(input logic dv, input logic [1:0] he, input logic [1:0] st,
                       input logic fl, input logic [4:0] ft);
    int   n;
    int   pos;
    logic full_m;
    logic c0;
    logic c1;
    drive(dv, he, st, fl, ft);
    #1;
    n      = q.size();
    full_m = (n == 16);
    pos    = -1;
    if (fl) for (int k = 0; k < n; k++) if (q[k] == int'(ft)) pos = k;
    c0 = (n > 0) && he[0];
    c1 = c0 && (n >= 2) && he[1] && !st[0] && !st[1] && (pos != 0);
    check("dispatch_ready", 32'(dispatch_ready), 32'(!full_m && !fl));
    check("commit_valid", 32'(commit_valid), 32'({c1, c0}));
    if (c0) check("commit_idx0", 32'(commit_idx0), 32'(q[0] % 16));
    if (c1) check("commit_idx1", 32'(commit_idx1), 32'(q[1] % 16));
    m_sq  = '0;
    m_err = fl && (pos < 0);
    if (fl && pos >= 0) begin
      for (int k = pos + 1; k < n; k++) m_sq |= 16'(1 << (q[k] % 16));
      while (q.size() > pos + 1) void'(q.pop_back());
      nxt = (int'(ft) + 1) % 32;
    end else if (dv && !full_m && !fl) begin
      q.push_back(nxt);
      nxt = (nxt + 1) % 32;
    end
    if (c0) void'(q.pop_front());
    if (c1) void'(q.pop_front());
    @(negedge clk);
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic alloc_n(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 2'b00, 2'b00, 1'b0, 5'd0);
  endtask

  task automatic commit_n(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'b01, 2'b00, 1'b0, 5'd0);
  endtask

  task automatic do_reset();
    drive(1'b0, 2'b00, 2'b00, 1'b0, 5'd0);
    reset = 1'b0;
    #1;
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int n;
    int r;
    logic [4:0] ft;
    reset = 1'b0;
    drive(1'b0, 2'b00, 2'b00, 1'b0, 5'd0);
    model_clear();
    @(posedge clk);
    #1;
    check("rst_commit_valid", 32'(commit_valid), 32'd0);
    check_state();
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Reset pulled mid-stream between edges.
    alloc_n(5);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_empty", 32'(empty), 32'd1);
    check("midrst_tag", 32'(dispatch_tag), 32'd0);
    check("midrst_commit", 32'(commit_valid), 32'd0);
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b1;
    check_state();

    // Fill to full, blocked dispatch, then wrap-bit tag.
    alloc_n(16);
    check("fill_full", 32'(full), 32'd1);
    cycle(1'b1, 2'b00, 2'b00, 1'b0, 5'd0);
    cycle(1'b1, 2'b01, 2'b00, 1'b0, 5'd0);
    check("wrap_tag", 32'(dispatch_tag), 32'd16);
    alloc_n(1);
    check("wrap_tag_next", 32'(dispatch_tag), 32'd17);

    // Dual commit, then store-limited commit.
    do_reset();
    alloc_n(7);
    commit_n(3);
    drive(1'b0, 2'b11, 2'b00, 1'b0, 5'd0);
    #1;
    check("dual_valid", 32'(commit_valid), 32'd3);
    check("dual_idx0", 32'(commit_idx0), 32'd3);
    check("dual_idx1", 32'(commit_idx1), 32'd4);
    cycle(1'b0, 2'b11, 2'b00, 1'b0, 5'd0);
    check("dual_count", 32'(count), 32'd2);
    drive(1'b0, 2'b11, 2'b01, 1'b0, 5'd0);
    #1;
    check("store_valid", 32'(commit_valid), 32'd1);
    cycle(1'b0, 2'b11, 2'b01, 1'b0, 5'd0);

    // Flush across the index wrap.
    do_reset();
    alloc_n(16);
    commit_n(14);
    alloc_n(4);
    cycle(1'b0, 2'b00, 2'b00, 1'b1, 5'd15);
    check("wflush_mask", 32'(squash_mask), 32'h000F);
    check("wflush_count", 32'(count), 32'd2);
    check("wflush_tail", 32'(dispatch_tag), 32'd16);
    cycle(1'b0, 2'b00, 2'b00, 1'b0, 5'd0);
    check("wflush_pulse", 32'(squash_mask), 32'd0);

    // Flush and commit in the same cycle.
    do_reset();
    alloc_n(5);
    commit_n(2);
    drive(1'b0, 2'b01, 2'b00, 1'b1, 5'd3);
    #1;
    check("fc_valid", 32'(commit_valid), 32'd1);
    check("fc_idx0", 32'(commit_idx0), 32'd2);
    cycle(1'b0, 2'b01, 2'b00, 1'b1, 5'd3);
    check("fc_mask", 32'(squash_mask), 32'h0010);
    check("fc_count", 32'(count), 32'd1);

    // Invalid flush, then flush of the youngest entry.
    do_reset();
    alloc_n(2);
    cycle(1'b0, 2'b00, 2'b00, 1'b1, 5'd5);
    check("iflush_err", 32'(flush_err), 32'd1);
    check("iflush_count", 32'(count), 32'd2);
    check("iflush_tag", 32'(dispatch_tag), 32'd2);
    cycle(1'b0, 2'b00, 2'b00, 1'b1, 5'd1);
    check("iflush_err_clr", 32'(flush_err), 32'd0);
    check("yflush_mask", 32'(squash_mask), 32'd0);
    check("yflush_tag", 32'(dispatch_tag), 32'd2);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      n  = q.size();
      r  = int'($urandom_range(0, 15));
      ft = 5'($urandom);
      if (r < 2 && n > 0) ft = 5'(q[$urandom_range(0, n - 1)]);
      cycle(($urandom_range(0, 3) != 0), 2'($urandom), 2'($urandom), (r < 3), ft);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
